// File: rtl/pipe_datapath_if.sv
// rtl/pipe_datapath_if.sv - instruction/data memory and controller bus of the pipelined datapath
interface pipe_datapath_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pcF;
  logic [31:0]      instrF;
  logic [31:0]      instrD;
  logic             regwriteD;
  logic             memtoregD;
  logic             memwriteD;
  logic             alusrcD;
  logic             regdstD;
  logic             branchD;
  logic             jumpD;
  logic [2:0]       alucontrolD;
  logic [WIDTH-1:0] aluoutM;
  logic [WIDTH-1:0] writedataM;
  logic             memwriteM;
  logic [WIDTH-1:0] readdataM;
  logic             regwriteW;
  logic [4:0]       writeregW;
  logic [WIDTH-1:0] resultW;
  logic             stallF;
  logic             flushE;

  modport master (
    output pcF, instrD, aluoutM, writedataM, memwriteM,
           regwriteW, writeregW, resultW, stallF, flushE,
    input  instrF, regwriteD, memtoregD, memwriteD, alusrcD, regdstD,
           branchD, jumpD, alucontrolD, readdataM
  );

  modport slave (
    input  pcF, instrD, aluoutM, writedataM, memwriteM,
           regwriteW, writeregW, resultW, stallF, flushE,
    output instrF, regwriteD, memtoregD, memwriteD, alusrcD, regdstD,
           branchD, jumpD, alucontrolD, readdataM
  );
endinterface

// File: rtl/pipe_datapath.sv
// rtl/pipe_datapath.sv - five-stage MIPS datapath with forwarding, load-use stall and branch/jump flush
module pipe_datapath #(
  parameter int               WIDTH    = 32,
  parameter int               FORWARD  = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  pipe_datapath_if.master bus
);

  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] pcplus4;
  } fd_t;

  typedef struct packed {
    logic             regwrite, memtoreg, memwrite, alusrc, regdst, branch;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] rd1, rd2, signimm, pcplus4;
    logic [4:0]       rs, rt, rd;
  } de_t;

  typedef struct packed {
    logic             regwrite, memtoreg, memwrite;
    logic [WIDTH-1:0] aluout, writedata;
    logic [4:0]       writereg;
  } em_t;

  typedef struct packed {
    logic             regwrite, memtoreg;
    logic [WIDTH-1:0] aluout, readdata;
    logic [4:0]       writereg;
  } mw_t;

  logic [WIDTH-1:0] pc_d, pc_q;
  fd_t fd_d, fd_q;
  de_t de_d, de_q;
  em_t em_d, em_q;
  mw_t mw_d, mw_q;
  logic [WIDTH-1:0] rf [32];

  logic [4:0]       rs_dec, rt_dec, rd_dec;
  logic [WIDTH-1:0] rd1_dec, rd2_dec, signimm_dec, jump_target, result_w;
  logic [WIDTH-1:0] src_a_ex, wdata_ex, src_b_ex, alu_ex, pcbranch_ex, pcplus4_f;
  logic [4:0]       writereg_ex;
  logic             pcsrc_ex, lwstall, depstall, stall_dec, jump_take;

  // Register reads see a same-cycle writeback, so W never needs forwarding into D.
  always_comb begin
    rs_dec   = fd_q.instr[25:21];
    rt_dec   = fd_q.instr[20:16];
    rd_dec   = fd_q.instr[15:11];
    result_w = mw_q.memtoreg ? mw_q.readdata : mw_q.aluout;
    rd1_dec  = '0;
    rd2_dec  = '0;
    if (rs_dec != 5'd0)
      rd1_dec = (mw_q.regwrite && mw_q.writereg == rs_dec) ? result_w : rf[rs_dec];
    if (rt_dec != 5'd0)
      rd2_dec = (mw_q.regwrite && mw_q.writereg == rt_dec) ? result_w : rf[rt_dec];
    signimm_dec = {{(WIDTH-16){fd_q.instr[15]}}, fd_q.instr[15:0]};
    jump_target = {fd_q.pcplus4[WIDTH-1:28], fd_q.instr[25:0], 2'b00};
  end

  always_comb begin
    src_a_ex = de_q.rd1;
    wdata_ex = de_q.rd2;
    if (FORWARD != 0) begin
      if (em_q.regwrite && em_q.writereg != 5'd0 && em_q.writereg == de_q.rs)
        src_a_ex = em_q.aluout;
      else if (mw_q.regwrite && mw_q.writereg != 5'd0 && mw_q.writereg == de_q.rs)
        src_a_ex = result_w;
      if (em_q.regwrite && em_q.writereg != 5'd0 && em_q.writereg == de_q.rt)
        wdata_ex = em_q.aluout;
      else if (mw_q.regwrite && mw_q.writereg != 5'd0 && mw_q.writereg == de_q.rt)
        wdata_ex = result_w;
    end
    src_b_ex = de_q.alusrc ? de_q.signimm : wdata_ex;
    case (de_q.alucontrol)
      3'b010:  alu_ex = src_a_ex + src_b_ex;
      3'b110:  alu_ex = src_a_ex - src_b_ex;
      3'b000:  alu_ex = src_a_ex & src_b_ex;
      3'b001:  alu_ex = src_a_ex | src_b_ex;
      3'b111:  alu_ex = {{(WIDTH-1){1'b0}}, $signed(src_a_ex) < $signed(src_b_ex)};
      default: alu_ex = '0;
    endcase
    writereg_ex = de_q.regdst ? de_q.rd : de_q.rt;
    pcbranch_ex = de_q.pcplus4 + {de_q.signimm[WIDTH-3:0], 2'b00};
    pcsrc_ex    = de_q.branch && (alu_ex == '0);
  end

  // Without forwarding, any in-flight writer in E or M of a D source must drain first.
  always_comb begin
    lwstall = de_q.memtoreg && de_q.regwrite && de_q.rt != 5'd0 &&
              (de_q.rt == rs_dec || de_q.rt == rt_dec);
    depstall = 1'b0;
    if (FORWARD == 0)
      depstall = (rs_dec != 5'd0 && ((de_q.regwrite && writereg_ex == rs_dec) ||
                                     (em_q.regwrite && em_q.writereg == rs_dec))) ||
                 (rt_dec != 5'd0 && ((de_q.regwrite && writereg_ex == rt_dec) ||
                                     (em_q.regwrite && em_q.writereg == rt_dec)));
    stall_dec = lwstall || depstall;
    jump_take = bus.jumpD && !stall_dec && !pcsrc_ex;
  end

  always_comb begin
    pcplus4_f = pc_q + WIDTH'(4);
    pc_d      = pcplus4_f;
    if (pcsrc_ex)       pc_d = pcbranch_ex;
    else if (stall_dec) pc_d = pc_q;
    else if (bus.jumpD) pc_d = jump_target;

    fd_d = fd_q;
    if (pcsrc_ex || jump_take) begin
      fd_d = '0;
    end else if (!stall_dec) begin
      fd_d.instr   = bus.instrF;
      fd_d.pcplus4 = pcplus4_f;
    end

    de_d = '0;
    if (!(stall_dec || pcsrc_ex)) begin
      de_d.regwrite   = bus.regwriteD;
      de_d.memtoreg   = bus.memtoregD;
      de_d.memwrite   = bus.memwriteD;
      de_d.alusrc     = bus.alusrcD;
      de_d.regdst     = bus.regdstD;
      de_d.branch     = bus.branchD;
      de_d.alucontrol = bus.alucontrolD;
      de_d.rd1        = rd1_dec;
      de_d.rd2        = rd2_dec;
      de_d.signimm    = signimm_dec;
      de_d.pcplus4    = fd_q.pcplus4;
      de_d.rs         = rs_dec;
      de_d.rt         = rt_dec;
      de_d.rd         = rd_dec;
    end

    em_d.regwrite  = de_q.regwrite;
    em_d.memtoreg  = de_q.memtoreg;
    em_d.memwrite  = de_q.memwrite;
    em_d.aluout    = alu_ex;
    em_d.writedata = wdata_ex;
    em_d.writereg  = writereg_ex;

    mw_d.regwrite = em_q.regwrite;
    mw_d.memtoreg = em_q.memtoreg;
    mw_d.aluout   = em_q.aluout;
    mw_d.readdata = bus.readdataM;
    mw_d.writereg = em_q.writereg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      fd_q <= '0;
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mw_q.regwrite && mw_q.writereg != 5'd0)
      rf[mw_q.writereg] <= result_w;
  end

  assign bus.pcF        = pc_q;
  assign bus.instrD     = fd_q.instr;
  assign bus.aluoutM    = em_q.aluout;
  assign bus.writedataM = em_q.writedata;
  assign bus.memwriteM  = em_q.memwrite;
  assign bus.regwriteW  = mw_q.regwrite;
  assign bus.writeregW  = mw_q.writereg;
  assign bus.resultW    = result_w;
  assign bus.stallF     = stall_dec && !pcsrc_ex;
  assign bus.flushE     = stall_dec || pcsrc_ex;

endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Five-stage pipelined successor to the single-cycle MIPS datapath: Fetch, Decode, Execute, Memory, Writeback.
- Parametrised data width.
- Built-in hazard handling:
  - EX-stage operand forwarding, selectable by parameter.
  - Load-use stall.
  - Branch and jump flushing.
- Sits between the existing main controller/ALU decoder, which decode instrD and drive the *D control inputs, and separate instruction and data memories.

Parameters:
- WIDTH, 32, datapath/register/PC width; must be ≥32 and a multiple of 8.
- FORWARD, 1, 1 = forwarding muxes enabled; 0 = every RAW hazard on an in-flight writer stalls in Decode.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all flops on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears state immediately
- pcF  out  WIDTH  instruction memory address
- instrF  in  32  fetched instruction
- instrD  out  32  Decode-stage instruction, to controller
- regwriteD, memtoregD, memwriteD, alusrcD, regdstD, branchD, jumpD  in  1 each  controller outputs for instrD
- alucontrolD  in  3  ALU operation for instrD
- aluoutM  out  WIDTH  data memory address
- writedataM  out  WIDTH  data memory store data
- memwriteM  out  1  data memory write enable
- readdataM  in  WIDTH  data memory read data (combinational)
- regwriteW  out  1  observation: writeback enable
- writeregW  out  5  observation: writeback register
- resultW  out  WIDTH  observation: writeback value
- stallF  out  1  observation: PC/IF-ID held this cycle
- flushE  out  1  observation: bubble inserted into ID/EX this cycle

Behaviour:
- Reset (reset=0, async):
  - pcF=RESET_PC.
  - All pipeline registers cleared: instr=0 (NOP), all control=0.
  - Register file contents are not reset.
  - All outputs are 0 except pcF.
  - Reset mid-operation discards every in-flight instruction; no write occurs.
- Register file:
  - 32×WIDTH; $0 reads 0 and ignores writes.
  - Write in W; a same-cycle read of the written register in D returns resultW (internal bypass).
- Sign extension: imm16 sign-extended to WIDTH. Branch target = pcplus4 + (signimm<<2), computed in EX. Jump target = {pcplus4D[WIDTH-1:28], instrD[25:0], 2'b00}, computed in D.
- Forwarding (FORWARD=1), for srcA (rsE) and srcB (rtE):
  - Select aluoutM if regwriteM && writeregM==rsE/rtE && writeregM!=0.
  - Else select resultW under the same conditions against writeregW.
  - Else use the register value. M has priority over W.
  - Forwarded rt value also feeds writedataE.
- Load-use stall: lwstall = memtoregE && regwriteE && (rtE==rsD || rtE==rtD) && rtE!=0.
  - PC and IF/ID hold; ID/EX loads a bubble.
  - Exactly 1 cycle per load-use pair.
- FORWARD=0: stall while any of rsD/rtD (nonzero) matches writereg of a regwrite instruction in E or M. The W match is covered by the regfile bypass.
- Taken branch: pcsrcE = branchE && zeroE.
  - Next PC = branch target.
  - IF/ID and ID/EX flushed to bubble; 2-cycle penalty.
  - Not-taken: no penalty.
- Jump (jumpD=1): next PC = jump target; IF/ID flushed; 1-cycle penalty. jumpD is not carried past D.
- Simultaneous events:
  - Taken branch in E overrides jump in D and any stall. The PC loads the branch target and the stall is dropped.
  - Stall overrides jump: jump is retaken after the stall clears.
- flushE = lwstall || pcsrcE || FORWARD=0 stall.
- PC wraps modulo 2^WIDTH.

Test Plan:
- Reset: hold reset=0 with clk running, release → pcF=0, then 4,8,…; resultW/regwriteW stay 0 for 4 cycles.
- ALU forwarding: addi $1,$0,5; add $2,$1,$1; sub $3,$2,$1 → resultW sequence 5,10,5; no stalls with FORWARD=1. With FORWARD=0 → same results, stallF pulses for 2 cycles on each dependent instruction (4 in total).
- Load-use: mem[0]=0x1234; lw $4,0($0); add $5,$4,$4 → stallF high for exactly 1 cycle, $5=0x2468.
- Taken branch: $1=$2=7; beq $1,$2,+2 at 0x10 → pcF becomes 0x1C; the two following instructions never write back (regwriteW=0 in their slots).
- Jump + stall: lw $6; j 0x40 with jump not dependent; then lw $6 followed by dependent jr-free j → pcF=0x40 after 1 bubble; no write to $0 even when targeted (addi $0,$0,9 → $0 reads 0).
- Async reset mid-stream: pull reset low between edges while sw is in M → memwriteM drops to 0 immediately; pcF=RESET_PC.
